// File: rtl/shift_seq_ctrl.sv
// Load/shift/capture sequencer for one parallel-load shift register.
// Takes a word and shift count from a valid/ready source and returns the shifted word.
module shift_seq_ctrl #(
    parameter int C_WIDTH      = 16,
    parameter int C_LEN_WIDTH  = 5,
    parameter int C_SHIFT_TYPE = 0,
    parameter int C_GAP        = 0
) (
    input  logic                   CLK,
    input  logic                   ACLR_N,
    input  logic [C_WIDTH-1:0]     TX_DATA,
    input  logic [C_LEN_WIDTH-1:0] TX_LEN,
    input  logic                   TX_DIR,
    input  logic                   TX_VALID,
    output logic                   TX_READY,
    input  logic                   ABORT,
    output logic [C_WIDTH-1:0]     SR_D,
    output logic                   SR_P_LOAD,
    output logic                   SR_CE,
    output logic                   SR_LSB_2_MSB,
    output logic                   SR_SCLR,
    input  logic [C_WIDTH-1:0]     SR_Q,
    output logic [C_WIDTH-1:0]     RX_DATA,
    output logic                   RX_VALID,
    input  logic                   RX_READY,
    output logic                   BUSY
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPT, HOLD, GAP} state_t;

    localparam logic [C_LEN_WIDTH-1:0] LEN_MAX = C_LEN_WIDTH'(C_WIDTH);
    localparam logic [C_LEN_WIDTH-1:0] CNT_ONE = C_LEN_WIDTH'(1);
    localparam logic                   DIR_RST = (C_SHIFT_TYPE == 1) ? 1'b0 : 1'b1;
    localparam logic [7:0]             GAP_LOAD = (C_GAP > 0) ? 8'(C_GAP - 1) : 8'd0;

    state_t                   state_q, state_d;
    logic [C_LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [7:0]               gap_q, gap_d;
    logic [C_WIDTH-1:0]       data_q, data_d;
    logic [C_WIDTH-1:0]       rxd_q, rxd_d;
    logic                     dir_q, dir_d;
    logic                     pl_q, pl_d;
    logic                     ce_q, ce_d;
    logic                     sclr_q, sclr_d;
    logic                     rxv_q, rxv_d;
    logic [C_LEN_WIDTH-1:0]   eff_len;
    logic                     dir_sel;

    // A zero or oversized request means a full-width shift, so the counter never starts at 0.
    assign eff_len = (TX_LEN == '0 || TX_LEN > LEN_MAX) ? LEN_MAX : TX_LEN;
    assign dir_sel = (C_SHIFT_TYPE == 2) ? TX_DIR : DIR_RST;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        data_d  = data_q;
        rxd_d   = rxd_q;
        dir_d   = dir_q;
        sclr_d  = 1'b0;
        if (ABORT) begin
            if (state_q != IDLE) begin
                state_d = IDLE;
                sclr_d  = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (TX_VALID) begin
                        state_d = LOAD;
                        data_d  = TX_DATA;
                        cnt_d   = eff_len;
                        dir_d   = dir_sel;
                    end
                end
                LOAD:  state_d = SHIFT;
                SHIFT: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_ONE) state_d = CAPT;
                end
                CAPT: begin
                    rxd_d   = SR_Q;
                    state_d = HOLD;
                end
                HOLD: begin
                    if (RX_READY) begin
                        if (C_GAP > 0) begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == 8'd0) state_d = IDLE;
                    else               gap_d   = gap_q - 8'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Register outputs are decoded from the next state so they line up with the state they belong to.
    assign pl_d  = (state_d == LOAD);
    assign ce_d  = (state_d == LOAD) || (state_d == SHIFT);
    assign rxv_d = (state_d == HOLD);

    always_ff @(posedge CLK or negedge ACLR_N) begin
        if (!ACLR_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= 8'd0;
            data_q  <= '0;
            rxd_q   <= '0;
            dir_q   <= DIR_RST;
            pl_q    <= 1'b0;
            ce_q    <= 1'b0;
            sclr_q  <= 1'b0;
            rxv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            rxd_q   <= rxd_d;
            dir_q   <= dir_d;
            pl_q    <= pl_d;
            ce_q    <= ce_d;
            sclr_q  <= sclr_d;
            rxv_q   <= rxv_d;
        end
    end

    assign TX_READY     = (state_q == IDLE);
    assign BUSY         = (state_q != IDLE);
    assign SR_D         = data_q;
    assign SR_P_LOAD    = pl_q;
    assign SR_CE        = ce_q;
    assign SR_LSB_2_MSB = dir_q;
    assign SR_SCLR      = sclr_q;
    assign RX_DATA      = rxd_q;
    assign RX_VALID     = rxv_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: an 8-bit lsb_to_msb instance (no gap) and a
// 16-bit bidirectional instance with a 3-cycle gap, each driving a behavioural shift register.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] tx_data;
    logic [4:0]  tx_len;
    logic        tx_dir;
    logic [1:0]  tx_valid, abort, rx_ready;
    wire  [1:0]  tx_ready, sr_pl, sr_ce, sr_l2m, sr_sclr, rx_valid, busy;
    wire  [7:0]  a_sr_d, a_rx_data;
    wire  [15:0] b_sr_d, b_rx_data;
    logic [7:0]  a_q;
    logic [15:0] b_q;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.C_WIDTH(8), .C_LEN_WIDTH(5), .C_SHIFT_TYPE(0), .C_GAP(0)) u_a (
        .CLK(clk), .ACLR_N(rst_n), .TX_DATA(tx_data[7:0]), .TX_LEN(tx_len), .TX_DIR(tx_dir),
        .TX_VALID(tx_valid[0]), .TX_READY(tx_ready[0]), .ABORT(abort[0]), .SR_D(a_sr_d),
        .SR_P_LOAD(sr_pl[0]), .SR_CE(sr_ce[0]), .SR_LSB_2_MSB(sr_l2m[0]), .SR_SCLR(sr_sclr[0]),
        .SR_Q(a_q), .RX_DATA(a_rx_data), .RX_VALID(rx_valid[0]), .RX_READY(rx_ready[0]),
        .BUSY(busy[0])
    );

    shift_seq_ctrl #(.C_WIDTH(16), .C_LEN_WIDTH(5), .C_SHIFT_TYPE(2), .C_GAP(3)) u_b (
        .CLK(clk), .ACLR_N(rst_n), .TX_DATA(tx_data), .TX_LEN(tx_len), .TX_DIR(tx_dir),
        .TX_VALID(tx_valid[1]), .TX_READY(tx_ready[1]), .ABORT(abort[1]), .SR_D(b_sr_d),
        .SR_P_LOAD(sr_pl[1]), .SR_CE(sr_ce[1]), .SR_LSB_2_MSB(sr_l2m[1]), .SR_SCLR(sr_sclr[1]),
        .SR_Q(b_q), .RX_DATA(b_rx_data), .RX_VALID(rx_valid[1]), .RX_READY(rx_ready[1]),
        .BUSY(busy[1])
    );

    // Shift register models, serial input tied to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            a_q <= '0;
        else if (sr_sclr[0])   a_q <= '0;
        else if (sr_ce[0]) begin
            if (sr_pl[0])       a_q <= a_sr_d;
            else if (sr_l2m[0]) a_q <= {a_q[6:0], 1'b0};
            else                a_q <= {1'b0, a_q[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            b_q <= '0;
        else if (sr_sclr[1])   b_q <= '0;
        else if (sr_ce[1]) begin
            if (sr_pl[1])       b_q <= b_sr_d;
            else if (sr_l2m[1]) b_q <= {b_q[14:0], 1'b0};
            else                b_q <= {1'b0, b_q[15:1]};
        end
    end

    function automatic logic [15:0] rxd(input bit i);
        return i ? b_rx_data : {8'h00, a_rx_data};
    endfunction

    function automatic logic [15:0] srd(input bit i);
        return i ? b_sr_d : {8'h00, a_sr_d};
    endfunction

    function automatic logic [15:0] regq(input bit i);
        return i ? b_q : {8'h00, a_q};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge with the instance idle; returns at the negedge where RX_VALID is seen.
    task automatic run_job(input bit i, input logic [15:0] data, input logic [4:0] len,
                           input logic dir, input int exp_shifts, input logic [15:0] exp_rx,
                           input logic exp_l2m);
        int shifts, lat, extra_pl, dir_bad;
        check_val("tx_ready_pre", tx_ready[i], 1);
        tx_data     = data;
        tx_len      = len;
        tx_dir      = dir;
        tx_valid[i] = 1'b1;
        @(negedge clk);
        tx_valid[i] = 1'b0;
        check_val("load_p_load", sr_pl[i], 1);
        check_val("load_ce", sr_ce[i], 1);
        check_val("load_sr_d", srd(i), data);
        check_val("load_busy", busy[i], 1);
        shifts = 0; lat = 0; extra_pl = 0; dir_bad = 0;
        while (!rx_valid[i] && lat < 40) begin
            @(negedge clk);
            lat++;
            if (sr_ce[i] && !sr_pl[i]) shifts++;
            if (sr_pl[i]) extra_pl++;
            if (sr_ce[i] && sr_l2m[i] != exp_l2m) dir_bad++;
        end
        check_val("shift_cycles", shifts, exp_shifts);
        check_val("rx_latency", lat, exp_shifts + 2);
        check_val("extra_p_load", extra_pl, 0);
        check_val("shift_dir", dir_bad, 0);
        check_val("rx_data", rxd(i), exp_rx);
    endtask

    // Holds RX_READY low for wait_cycles, handshakes, then measures cycles until TX_READY returns.
    task automatic handshake(input bit i, input int wait_cycles, input int exp_gap);
        logic [15:0] d0;
        int unstable, g;
        d0 = rxd(i);
        unstable = 0;
        for (int k = 0; k < wait_cycles; k++) begin
            @(negedge clk);
            if (!rx_valid[i] || rxd(i) != d0) unstable++;
        end
        check_val("hold_stable", unstable, 0);
        rx_ready[i] = 1'b1;
        @(negedge clk);
        rx_ready[i] = 1'b0;
        check_val("rx_valid_drop", rx_valid[i], 0);
        g = 0;
        while (!tx_ready[i] && g < 20) begin
            @(negedge clk);
            g++;
        end
        check_val("gap_cycles", g, exp_gap);
    endtask

    initial begin
        int late_valid;
        rst_n = 1'b0; tx_data = '0; tx_len = '0; tx_dir = 1'b0;
        tx_valid = '0; abort = '0; rx_ready = '0;
        #12;
        for (int i = 0; i < 2; i++) begin
            check_val("rst_tx_ready", tx_ready[i], 1);
            check_val("rst_busy", busy[i], 0);
            check_val("rst_p_load", sr_pl[i], 0);
            check_val("rst_ce", sr_ce[i], 0);
            check_val("rst_sclr", sr_sclr[i], 0);
            check_val("rst_rx_valid", rx_valid[i], 0);
            check_val("rst_l2m", sr_l2m[i], 1);
        end
        check_val("rst_rx_data_a", rxd(1'b0), 0);
        check_val("rst_sr_d_b", srd(1'b1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rel_tx_ready", tx_ready, 2'b11);
        check_val("rel_busy", busy, 2'b00);

        // 8-bit lsb_to_msb instance
        run_job(1'b0, 16'h0081, 5'd3, 1'b0, 3, 16'h0008, 1'b1);
        handshake(1'b0, 0, 0);
        run_job(1'b0, 16'h003C, 5'd2, 1'b0, 2, 16'h00F0, 1'b1);
        handshake(1'b0, 0, 0);
        run_job(1'b0, 16'h00A5, 5'd0, 1'b0, 8, 16'h0000, 1'b1);
        handshake(1'b0, 2, 0);

        tx_valid[0] = 1'b1;
        abort[0]    = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        abort[0]    = 1'b0;
        check_val("idle_abort_busy", busy[0], 0);
        check_val("idle_abort_sclr", sr_sclr[0], 0);
        check_val("idle_abort_ready", tx_ready[0], 1);

        tx_data = 16'h0081; tx_len = 5'd8; tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check_val("abort_sclr", sr_sclr[0], 1);
        check_val("abort_ce", sr_ce[0], 0);
        check_val("abort_busy", busy[0], 0);
        check_val("abort_ready", tx_ready[0], 1);
        @(negedge clk);
        check_val("abort_sclr_end", sr_sclr[0], 0);
        check_val("abort_reg_clr", regq(1'b0), 0);
        late_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (rx_valid[0]) late_valid++;
        end
        check_val("abort_no_rx", late_valid, 0);

        // 16-bit bidirectional instance with gap
        run_job(1'b1, 16'h1234, 5'd0, 1'b1, 16, 16'h0000, 1'b1);
        handshake(1'b1, 0, 3);
        run_job(1'b1, 16'hBEEF, 5'd20, 1'b1, 16, 16'h0000, 1'b1);
        handshake(1'b1, 0, 3);
        run_job(1'b1, 16'h0081, 5'd1, 1'b0, 1, 16'h0040, 1'b0);
        check_val("bidir_hold_dir", sr_l2m[1], 0);
        handshake(1'b1, 10, 3);
        check_val("bidir_idle_dir", sr_l2m[1], 0);
        run_job(1'b1, 16'h0081, 5'd4, 1'b1, 4, 16'h0810, 1'b1);
        handshake(1'b1, 0, 3);

        run_job(1'b1, 16'h0081, 5'd1, 1'b1, 1, 16'h0102, 1'b1);
        abort[1]    = 1'b1;
        rx_ready[1] = 1'b1;
        @(negedge clk);
        abort[1]    = 1'b0;
        rx_ready[1] = 1'b0;
        check_val("hold_abort_rx_valid", rx_valid[1], 0);
        check_val("hold_abort_sclr", sr_sclr[1], 1);
        check_val("hold_abort_ready", tx_ready[1], 1);

        // Asynchronous reset in the middle of a shift
        @(negedge clk);
        tx_data = 16'hFFFF; tx_len = 5'd16; tx_dir = 1'b0; tx_valid[1] = 1'b1;
        @(negedge clk);
        tx_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_val("pre_reset_ce", sr_ce[1], 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_ce", sr_ce[1], 0);
        check_val("arst_p_load", sr_pl[1], 0);
        check_val("arst_sclr", sr_sclr[1], 0);
        check_val("arst_busy", busy[1], 0);
        check_val("arst_tx_ready", tx_ready[1], 1);
        check_val("arst_sr_d", srd(1'b1), 0);
        check_val("arst_rx_data", rxd(1'b1), 0);
        check_val("arst_l2m", sr_l2m[1], 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("arst_rel_ready", tx_ready[1], 1);
        check_val("arst_rel_busy", busy[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
